// File: rtl/v_fltr_seq.sv
// v_fltr_seq: sequencer for the 7-tap vertical filter bank (delay-line strobe, window fill, output markers).
// Define V_FLTR_SEQ_FLUSH_EN to zero-fill the last C lines after each frame so the bottom rows are emitted too.
//
// state | meaning
// IDLE  | waiting for pix_sof; other pixels are dropped
// FILL  | first V_TAPS-1 lines shifting into the window, no outputs
// RUN   | window full, one output per accepted pixel
// FLUSH | zero-fill shifts pushing out the last C lines (V_FLTR_SEQ_FLUSH_EN only)
module v_fltr_seq #(
  parameter int H_LEN    = 496,
  parameter int V_LEN    = 480,
  parameter int V_TAPS   = 7,
  parameter int PIPE_LAT = 3
) (
  input  logic       tm3_clk_v0,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       pix_sof,
  output logic       pix_ready,
  output logic       shift_en,
  output logic [7:0] fltr_din,
  output logic       out_valid,
  output logic [8:0] out_col,
  output logic [9:0] out_row,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy,
  output logic       line_err,
  input  logic       clr_err
);

  localparam int         C        = (V_TAPS - 1) / 2;
  localparam logic [8:0] COL_LAST = 9'(H_LEN - 1);
  localparam logic [9:0] ROW_RUN  = 10'(V_TAPS - 1);
  localparam logic [9:0] ROW_LAST = 10'(V_LEN - 1);
  localparam logic [9:0] ROW_C    = 10'(C);
`ifdef V_FLTR_SEQ_FLUSH_EN
  // row keeps counting past the frame during flush so out_row = row - C stays correct
  localparam logic [9:0] ROW_FLUSH_LAST = 10'(V_LEN - 1 + C);
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
`ifdef V_FLTR_SEQ_FLUSH_EN
  localparam logic [1:0] ST_FLUSH = 2'd3;
`endif

  logic [1:0] state, state_nxt;
  logic [8:0] col, col_nxt, col_inc;
  logic [9:0] row, row_nxt, row_inc;
  logic       col_last;
  logic       accept;
  logic       shift_nxt;
  logic [7:0] din_nxt;
  logic       gen_vld, gen_sof, gen_eof, err_set;
  logic [8:0] gen_col;
  logic [9:0] gen_row;

  logic [PIPE_LAT:0] vld_pipe, sof_pipe, eof_pipe;
  logic [8:0]        col_pipe [0:PIPE_LAT];
  logic [9:0]        row_pipe [0:PIPE_LAT];

`ifdef V_FLTR_SEQ_FLUSH_EN
  assign pix_ready = (state != ST_FLUSH);
`else
  assign pix_ready = 1'b1;
`endif
  assign accept = pix_valid & pix_ready;
  assign busy   = (state != ST_IDLE);

  assign col_last = (col == COL_LAST);
  assign col_inc  = col_last ? 9'd0 : col + 9'd1;
  assign row_inc  = col_last ? row + 10'd1 : row;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    shift_nxt = 1'b0;
    din_nxt   = fltr_din;
    gen_vld   = 1'b0;
    gen_sof   = 1'b0;
    gen_eof   = 1'b0;
    err_set   = 1'b0;
    gen_col   = col;
    gen_row   = row - ROW_C;
    case (state)
      ST_IDLE: begin
        if (accept && pix_sof) begin
          shift_nxt = 1'b1;
          din_nxt   = pix_in;
          col_nxt   = 9'd1;
          row_nxt   = 10'd0;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL, ST_RUN: begin
        if (accept) begin
          shift_nxt = 1'b1;
          din_nxt   = pix_in;
          if (pix_sof && (col != 9'd0 || row != 10'd0)) begin
            // misplaced sof: restart the frame with this pixel as (0,0)
            err_set   = 1'b1;
            col_nxt   = 9'd1;
            row_nxt   = 10'd0;
            state_nxt = ST_FILL;
          end else begin
            col_nxt = col_inc;
            row_nxt = row_inc;
            if (state == ST_FILL) begin
              if (col_last && row_inc == ROW_RUN)
                state_nxt = ST_RUN;
            end else begin
              gen_vld = 1'b1;
              gen_sof = (row == ROW_RUN) && (col == 9'd0);
              if (row == ROW_LAST && col_last) begin
`ifdef V_FLTR_SEQ_FLUSH_EN
                state_nxt = ST_FLUSH;
`else
                gen_eof   = 1'b1;
                state_nxt = ST_IDLE;
                col_nxt   = 9'd0;
                row_nxt   = 10'd0;
`endif
              end
            end
          end
        end
      end
`ifdef V_FLTR_SEQ_FLUSH_EN
      ST_FLUSH: begin
        shift_nxt = 1'b1;
        din_nxt   = 8'd0;
        gen_vld   = 1'b1;
        col_nxt   = col_inc;
        row_nxt   = row_inc;
        if (row == ROW_FLUSH_LAST && col_last) begin
          gen_eof   = 1'b1;
          state_nxt = ST_IDLE;
          col_nxt   = 9'd0;
          row_nxt   = 10'd0;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tm3_clk_v0 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      col      <= 9'd0;
      row      <= 10'd0;
      shift_en <= 1'b0;
      fltr_din <= 8'd0;
      line_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      shift_en <= shift_nxt;
      fltr_din <= din_nxt;
      if (err_set)
        line_err <= 1'b1;
      else if (clr_err)
        line_err <= 1'b0;
    end
  end

  // marker pipe matches the filter latency so markers line up with dout
  always_ff @(posedge tm3_clk_v0 or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      eof_pipe <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        col_pipe[i] <= 9'd0;
        row_pipe[i] <= 10'd0;
      end
    end else begin
      vld_pipe    <= {vld_pipe[PIPE_LAT-1:0], gen_vld};
      sof_pipe    <= {sof_pipe[PIPE_LAT-1:0], gen_sof};
      eof_pipe    <= {eof_pipe[PIPE_LAT-1:0], gen_eof};
      col_pipe[0] <= gen_col;
      row_pipe[0] <= gen_row;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        col_pipe[i] <= col_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[PIPE_LAT];
  assign out_sof   = sof_pipe[PIPE_LAT];
  assign out_eof   = eof_pipe[PIPE_LAT];
  assign out_col   = col_pipe[PIPE_LAT];
  assign out_row   = row_pipe[PIPE_LAT];

endmodule
